// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Purpose  : BCD mm:ss countdown timer (00:00-99:59) advanced by the one-cycle
//            prescaler rollover strobe. Load/start/pause/clear control through
//            a four-state FSM (IDLE, RUN, PAUSE, ALARM). Expiry raises a
//            one-cycle done pulse and holds alarm for ALARM_TICKS ticks.
// Ports    : clk, aclr (async, active high)
//            tick, load, start, pause, clear  - one-cycle requests
//            load_min / load_sec              - BCD load value
//            min_bcd / sec_bcd                - current count, BCD
//            state, running, alarm            - FSM status
//            done, load_err                   - one-cycle event pulses
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer #(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] state,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic       load_err
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_PAUSE = 2'd2;
  localparam logic [1:0] c_ALARM = 2'd3;

  localparam logic [7:0] c_ALARM_LAST = 8'(ALARM_TICKS);

  logic [1:0] state_q, state_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] acnt_q, acnt_d;
  logic       done_q, done_d;
  logic       load_err_q, load_err_d;
  logic       running_q, alarm_q;

  logic [7:0] w_dec_min;
  logic [7:0] w_dec_sec;
  logic       w_load_ok;
  logic       w_cnt_zero;
  logic       w_cnt_one;
  logic       w_ld_state;

  assign w_load_ok  = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                      (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9);
  assign w_cnt_zero = (min_q == 8'h00) && (sec_q == 8'h00);
  assign w_cnt_one  = (min_q == 8'h00) && (sec_q == 8'h01);
  assign w_ld_state = (state_q == c_IDLE) || (state_q == c_PAUSE);

  // Digit-wise BCD decrement with borrow ripple; each digit wraps within its
  // own legal range so the fields never leave BCD.
  always_comb begin
    w_dec_sec = sec_q;
    w_dec_min = min_q;
    if (sec_q[3:0] != 4'd0) begin
      w_dec_sec[3:0] = sec_q[3:0] - 4'd1;
    end else begin
      w_dec_sec[3:0] = 4'd9;
      if (sec_q[7:4] != 4'd0) begin
        w_dec_sec[7:4] = sec_q[7:4] - 4'd1;
      end else begin
        w_dec_sec[7:4] = 4'd5;
        if (min_q[3:0] != 4'd0) begin
          w_dec_min[3:0] = min_q[3:0] - 4'd1;
        end else if (min_q[7:4] != 4'd0) begin
          w_dec_min[3:0] = 4'd9;
          w_dec_min[7:4] = min_q[7:4] - 4'd1;
        end
      end
    end
  end

  // Request priority chain: clear > load > start > pause > tick. A request
  // that does not apply in the current state falls through to the next one.
  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    sec_d      = sec_q;
    acnt_d     = acnt_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      state_d = c_IDLE;
      min_d   = 8'h00;
      sec_d   = 8'h00;
      acnt_d  = 8'd0;
    end else if (load && w_ld_state) begin
      if (w_load_ok) begin
        min_d = load_min;
        sec_d = load_sec;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (start && w_ld_state && !w_cnt_zero) begin
      state_d = c_RUN;
    end else if (pause && (state_q == c_RUN)) begin
      state_d = c_PAUSE;
    end else if (tick) begin
      if (state_q == c_RUN) begin
        if (w_cnt_one) begin
          min_d   = 8'h00;
          sec_d   = 8'h00;
          state_d = c_ALARM;
          done_d  = 1'b1;
          acnt_d  = 8'd0;
        end else begin
          min_d = w_dec_min;
          sec_d = w_dec_sec;
        end
      end else if (state_q == c_ALARM) begin
        if (acnt_q + 8'd1 == c_ALARM_LAST) begin
          state_d = c_IDLE;
          acnt_d  = 8'd0;
        end else begin
          acnt_d = acnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q    <= c_IDLE;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      acnt_q     <= 8'd0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      running_q  <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      acnt_q     <= acnt_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
      // Status flags registered from the next state so they are true flops.
      running_q  <= (state_d == c_RUN);
      alarm_q    <= (state_d == c_ALARM);
    end
  end

  assign min_bcd  = min_q;
  assign sec_bcd  = sec_q;
  assign state    = state_q;
  assign running  = running_q;
  assign done     = done_q;
  assign alarm    = alarm_q;
  assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer
// Purpose  : Self-checking bench for countdown_timer: directed vector table,
//            multi-cycle sequences, async clear, and randomized traffic
//            compared against a seconds-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

  localparam int unsigned ALARM_TICKS = 10;

  logic       clk;
  logic       aclr;
  logic       tick, load, start, pause, clear;
  logic [7:0] load_min, load_sec;
  logic [7:0] min_bcd, sec_bcd;
  logic [1:0] state;
  logic       running, done, alarm, load_err;

  int errors = 0;
  int checks = 0;

  // Reference model: count kept as plain seconds
  int m_state;
  int m_secs;
  int m_acnt;
  bit m_done;
  bit m_lerr;

  countdown_timer #(.ALARM_TICKS(ALARM_TICKS)) dut (
    .clk(clk), .aclr(aclr), .tick(tick), .load(load), .start(start),
    .pause(pause), .clear(clear), .load_min(load_min), .load_sec(load_sec),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .state(state), .running(running),
    .done(done), .alarm(alarm), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       c, l, s, p, t;
    logic [7:0] lm, ls;
    logic [7:0] e_min, e_sec;
    logic [1:0] e_st;
    logic       e_done, e_lerr;
  } vec_t;

  vec_t vecs[21];

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [21:0] dut_vec();
    return {min_bcd, sec_bcd, state, running, done, alarm, load_err};
  endfunction

  function automatic logic [21:0] model_vec();
    return {to_bcd(m_secs / 60), to_bcd(m_secs % 60), 2'(m_state),
            (m_state == 1), m_done, (m_state == 3), m_lerr};
  endfunction

  function automatic logic [21:0] mk(input logic [7:0] mn, input logic [7:0] sc,
                                     input logic [1:0] st, input logic d,
                                     input logic le);
    return {mn, sc, st, (st == 2'd1), d, (st == 2'd3), le};
  endfunction

  task automatic model_reset();
    m_state = 0; m_secs = 0; m_acnt = 0; m_done = 0; m_lerr = 0;
  endtask

  task automatic model_step(input logic c, l, s, p, t, input logic [7:0] lm, ls);
    int mt, mo, st, so;
    mt = int'(lm[7:4]); mo = int'(lm[3:0]);
    st = int'(ls[7:4]); so = int'(ls[3:0]);
    m_done = 0;
    m_lerr = 0;
    if (c) begin
      m_state = 0; m_secs = 0; m_acnt = 0;
    end else if (l && (m_state == 0 || m_state == 2)) begin
      if (mt <= 9 && mo <= 9 && st <= 5 && so <= 9)
        m_secs = (mt * 10 + mo) * 60 + st * 10 + so;
      else
        m_lerr = 1;
    end else if (s && (m_state == 0 || m_state == 2) && m_secs != 0) begin
      m_state = 1;
    end else if (p && m_state == 1) begin
      m_state = 2;
    end else if (t) begin
      if (m_state == 1) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_state = 3; m_done = 1; m_acnt = 0;
        end
      end else if (m_state == 3) begin
        m_acnt = m_acnt + 1;
        if (m_acnt == int'(ALARM_TICKS)) m_state = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive requests, take the edge, update model, sample at +1.
  task automatic cyc(input logic c, l, s, p, t, input logic [7:0] lm, ls);
    clear = c; load = l; start = s; pause = p; tick = t;
    load_min = lm; load_sec = ls;
    @(posedge clk);
    model_step(c, l, s, p, t, lm, ls);
    #1;
    clear = 0; load = 0; start = 0; pause = 0; tick = 0;
  endtask

  task automatic check_scalar(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int dones;
    int alarm_ticks;
    logic pre_alarm;
    logic [7:0] rlm, rls;

    vecs[0]  = '{0,1,0,0,0, 8'h10,8'h00, 8'h10,8'h00,2'd0,0,0};
    vecs[1]  = '{0,0,1,0,0, 8'h00,8'h00, 8'h10,8'h00,2'd1,0,0};
    vecs[2]  = '{0,0,0,0,1, 8'h00,8'h00, 8'h09,8'h59,2'd1,0,0};
    vecs[3]  = '{0,0,0,1,1, 8'h00,8'h00, 8'h09,8'h59,2'd2,0,0};
    vecs[4]  = '{0,1,0,0,0, 8'h01,8'h00, 8'h01,8'h00,2'd2,0,0};
    vecs[5]  = '{0,0,1,0,0, 8'h00,8'h00, 8'h01,8'h00,2'd1,0,0};
    vecs[6]  = '{0,0,0,0,1, 8'h00,8'h00, 8'h00,8'h59,2'd1,0,0};
    vecs[7]  = '{0,1,0,0,0, 8'h02,8'h00, 8'h00,8'h59,2'd1,0,0};
    vecs[8]  = '{1,0,0,0,0, 8'h00,8'h00, 8'h00,8'h00,2'd0,0,0};
    vecs[9]  = '{0,1,0,0,0, 8'h00,8'h60, 8'h00,8'h00,2'd0,0,1};
    vecs[10] = '{0,0,0,0,0, 8'h00,8'h00, 8'h00,8'h00,2'd0,0,0};
    vecs[11] = '{0,1,0,0,0, 8'h1A,8'h00, 8'h00,8'h00,2'd0,0,1};
    vecs[12] = '{0,0,1,0,0, 8'h00,8'h00, 8'h00,8'h00,2'd0,0,0};
    vecs[13] = '{0,1,0,0,0, 8'h00,8'h02, 8'h00,8'h02,2'd0,0,0};
    vecs[14] = '{0,0,1,0,0, 8'h00,8'h00, 8'h00,8'h02,2'd1,0,0};
    vecs[15] = '{0,0,0,0,1, 8'h00,8'h00, 8'h00,8'h01,2'd1,0,0};
    vecs[16] = '{1,0,0,0,1, 8'h00,8'h00, 8'h00,8'h00,2'd0,0,0};
    vecs[17] = '{0,1,0,0,0, 8'h00,8'h01, 8'h00,8'h01,2'd0,0,0};
    vecs[18] = '{0,0,1,0,0, 8'h00,8'h00, 8'h00,8'h01,2'd1,0,0};
    vecs[19] = '{0,0,0,0,1, 8'h00,8'h00, 8'h00,8'h00,2'd3,1,0};
    vecs[20] = '{0,0,0,0,1, 8'h00,8'h00, 8'h00,8'h00,2'd3,0,0};

    aclr = 1; clear = 0; load = 0; start = 0; pause = 0; tick = 0;
    load_min = 0; load_sec = 0;
    model_reset();
    #12;
    check("reset", dut_vec(), 22'h0);
    aclr = 0;

    // Directed table
    for (int i = 0; i < 21; i++) begin
      cyc(vecs[i].c, vecs[i].l, vecs[i].s, vecs[i].p, vecs[i].t, vecs[i].lm, vecs[i].ls);
      check($sformatf("vec%0d", i), dut_vec(),
            mk(vecs[i].e_min, vecs[i].e_sec, vecs[i].e_st, vecs[i].e_done, vecs[i].e_lerr));
      check($sformatf("vec%0d_model", i), dut_vec(), model_vec());
    end

    // Asynchronous clear in ALARM, mid-cycle, no clock edge
    #3 aclr = 1;
    #1 check("async_aclr", dut_vec(), 22'h0);
    model_reset();
    #2 aclr = 0;

    // 00:03 with a tick every fourth clock, through the full alarm
    cyc(0,1,0,0,0, 8'h00, 8'h03);
    cyc(0,0,1,0,0, 8'h00, 8'h00);
    dones = 0; alarm_ticks = 0;
    for (int i = 0; i < 60; i++) begin
      pre_alarm = alarm;
      cyc(0,0,0,0,(i % 4 == 3), 8'h00, 8'h00);
      if (done) dones++;
      if ((i % 4 == 3) && pre_alarm) alarm_ticks++;
      check($sformatf("seq3_c%0d", i), dut_vec(), model_vec());
    end
    check_scalar("seq3_done_count", dones, 1);
    check_scalar("seq3_alarm_ticks", alarm_ticks, int'(ALARM_TICKS));
    check("seq3_end", dut_vec(), mk(8'h00, 8'h00, 2'd0, 0, 0));

    // 05:30, 3 ticks, pause, 5 ticks, resume, 2 ticks -> 05:25
    cyc(0,1,0,0,0, 8'h05, 8'h30);
    cyc(0,0,1,0,0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0,0,0,0,1, 8'h00, 8'h00);
    cyc(0,0,0,1,0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc(0,0,0,0,1, 8'h00, 8'h00);
      check_scalar($sformatf("pause_running%0d", i), int'(running), 0);
    end
    cyc(0,0,1,0,0, 8'h00, 8'h00);
    cyc(0,0,0,0,1, 8'h00, 8'h00);
    cyc(0,0,0,0,1, 8'h00, 8'h00);
    check("seq530_end", dut_vec(), mk(8'h05, 8'h25, 2'd1, 0, 0));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rlm = 8'($urandom);
        rls = 8'($urandom);
      end else begin
        rlm = ($urandom_range(0, 7) == 0) ? to_bcd(int'($urandom_range(0, 99))) : 8'h00;
        rls = to_bcd(int'($urandom_range(0, 59)));
      end
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 45, rlm, rls);
      check($sformatf("rand%0d", i), dut_vec(), model_vec());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
